// File: rtl/rheed_result_packer.sv
// rtl/rheed_result_packer.sv - buffers one CNN result set and emits it as a framed 256-bit stream packet
// Optional header timestamp: define RHEED_PACKER_TIMESTAMP_EN.
module rheed_result_packer #(
  parameter int          NUM_CROPS = 5,
  parameter int          RES_W     = 160,
  parameter logic [31:0] MAGIC     = 32'h52484545
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [NUM_CROPS*RES_W-1:0] s_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [255:0]               m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic                       busy,
  output logic [31:0]                frame_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, CROP} state_t;

  localparam logic [7:0] LAST_K = 8'(NUM_CROPS - 1);

  state_t                     r_state;
  logic [7:0]                 r_k;
  logic [NUM_CROPS*RES_W-1:0] r_buf;
  logic [255:0]               r_tdata;
  logic                       r_tvalid;
  logic                       r_tlast;
  logic                       r_busy;
  logic [31:0]                r_frame_cnt;
  logic [63:0]                w_ts;
  logic [255:0]               w_hdr;
  logic [7:0]                 w_k_next;

`ifdef RHEED_PACKER_TIMESTAMP_EN
  logic [63:0] r_ts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 64'd1;
  end

  assign w_ts = r_ts;
`else
  assign w_ts = '0;
`endif

  function automatic logic [255:0] crop_word(input logic [NUM_CROPS*RES_W-1:0] data_i,
                                             input logic [7:0] idx);
    logic [255:0] w;
    w               = '0;
    w[RES_W-1:0]    = data_i[int'(idx)*RES_W +: RES_W];
    w[RES_W +: 8]   = idx;
    return w;
  endfunction

  always_comb begin
    w_hdr          = '0;
    w_hdr[31:0]    = MAGIC;
    w_hdr[63:32]   = r_frame_cnt;
    w_hdr[71:64]   = 8'(NUM_CROPS);
    w_hdr[191:128] = w_ts;
  end

  assign w_k_next = r_k + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_buf       <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_tvalid) begin
            r_buf       <= s_tdata;
            r_tdata     <= w_hdr;
            r_tvalid    <= 1'b1;
            r_tlast     <= 1'b0;
            r_busy      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 32'd1;
            r_state     <= HDR;
          end
        end
        HDR: begin
          if (m_axis_tready) begin
            r_k     <= '0;
            r_tdata <= crop_word(r_buf, 8'd0);
            r_tlast <= (LAST_K == 8'd0);
            r_state <= CROP;
          end
        end
        CROP: begin
          if (m_axis_tready) begin
            if (r_k == LAST_K) begin
              r_tdata  <= '0;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_busy   <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_k     <= w_k_next;
              r_tdata <= crop_word(r_buf, w_k_next);
              r_tlast <= (w_k_next == LAST_K);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Only s_tready is decoded from state so a set can be accepted in the first IDLE cycle.
  assign s_tready      = (r_state == IDLE);
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;
  assign busy          = r_busy;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_rheed_result_packer.sv
// tb/tb_rheed_result_packer.sv - scoreboard bench for rheed_result_packer
module tb_rheed_result_packer;
  localparam int NC = 5;
  localparam int RW = 160;

  typedef struct {
    logic [255:0] d;
    logic         l;
    logic         h;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            s_tvalid = 1'b0;
  logic            s_tready;
  logic [NC*RW-1:0] s_tdata = '0;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic [255:0]    m_tdata;
  logic            m_tlast;
  logic            busy;
  logic [31:0]     frame_cnt;

  logic            s1_tvalid = 1'b0;
  logic            s1_tready;
  logic [RW-1:0]   s1_tdata = '0;
  logic            m1_tvalid;
  logic            m1_tready = 1'b1;
  logic [255:0]    m1_tdata;
  logic            m1_tlast;
  logic            busy1;
  logic [31:0]     frame_cnt1;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc;
  int   model_cnt = 0;
  int   n_words = 0;
  bit   rand_rdy = 1'b0;
  exp_t exp_q[$];
  int   hdr_cyc[$];

  always #5 clk = ~clk;

  rheed_result_packer #(.NUM_CROPS(NC), .RES_W(RW)) u_dut (
    .clk(clk), .reset(reset), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast), .busy(busy), .frame_cnt(frame_cnt));

  rheed_result_packer #(.NUM_CROPS(1), .RES_W(RW)) u_dut1 (
    .clk(clk), .reset(reset), .s_tvalid(s1_tvalid), .s_tready(s1_tready), .s_tdata(s1_tdata),
    .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready), .m_axis_tdata(m1_tdata),
    .m_axis_tlast(m1_tlast), .busy(busy1), .frame_cnt(frame_cnt1));

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference packet: header then one word per crop, laid out field by field.
  task automatic push_set(input logic [NC*RW-1:0] d, input int fn, input logic [63:0] ts);
    exp_t e;
    e.d = '0; e.d[31:0] = 32'h52484545; e.d[63:32] = 32'(fn); e.d[71:64] = 8'(NC);
    e.d[191:128] = ts; e.l = 1'b0; e.h = 1'b1;
    exp_q.push_back(e);
    for (int k = 0; k < NC; k++) begin
      e.d = '0; e.d[RW-1:0] = d[k*RW +: RW]; e.d[RW +: 8] = 8'(k);
      e.l = (k == NC - 1); e.h = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [NC*RW-1:0] d, input bit hold);
    bit         rdy, ok;
    logic [63:0] ts;
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = d;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      rdy = s_tready;
`ifdef RHEED_PACKER_TIMESTAMP_EN
      ts = 64'(cyc);
`else
      ts = '0;
`endif
      @(posedge clk);
      if (rdy) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      push_set(d, model_cnt, ts);
      model_cnt++;
    end else chk("accept_timeout", 256'(ok), 256'd1);
    if (!hold) begin
      @(negedge clk);
      s_tvalid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && (exp_q.size() != 0 || m_tvalid); t++) @(negedge clk);
    chk("drain_pending", 256'(exp_q.size()), 256'd0);
  endtask

  function automatic logic [NC*RW-1:0] rand_set();
    logic [NC*RW-1:0] d;
    for (int i = 0; i < NC*RW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  bit           have_stall = 1'b0;
  logic [255:0] stall_d;
  logic         stall_l;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      have_stall = 1'b0;
    end else begin
      chk("s_tready_vs_packet", 256'(s_tready), 256'(!m_tvalid));
      chk("busy_vs_packet", 256'(busy), 256'(m_tvalid));
      if (have_stall) begin
        chk("stall_valid", 256'(m_tvalid), 256'd1);
        chk("stall_data", m_tdata, stall_d);
        chk("stall_last", 256'(m_tlast), 256'(stall_l));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 256'(m_tvalid), 256'd0);
        else begin
          e = exp_q.pop_front();
          n_words++;
          if (e.h) hdr_cyc.push_back(cyc);
          chk(e.h ? "hdr_data" : "crop_data", m_tdata, e.d);
          chk("tlast", 256'(m_tlast), 256'(e.l));
        end
      end
      have_stall = m_tvalid && !m_tready;
      stall_d    = m_tdata;
      stall_l    = m_tlast;
    end
  end

  initial begin
    logic [NC*RW-1:0] d;
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC*RW-1:0] d;
    #23;
    chk("rst_s_tready", 256'(s_tready), 256'd1);
    chk("rst_tvalid", 256'(m_tvalid), 256'd0);
    chk("rst_tlast", 256'(m_tlast), 256'd0);
    chk("rst_tdata", m_tdata, 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_frame_cnt", 256'(frame_cnt), 256'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed set, accepted 100 cycles after reset release.
    for (int k = 0; k < NC; k++) d[k*RW +: RW] = RW'(8'hA0 + k);
    while (cyc < 99) @(negedge clk);
    send(d, 1'b0);
    drain();
    chk("t1_words", 256'(n_words), 256'd6);
    chk("t1_frame_cnt", 256'(frame_cnt), 256'(model_cnt));

    // Random backpressure over three sets.
    n_words  = 0;
    rand_rdy = 1'b1;
    for (int p = 0; p < 3; p++) send(rand_set(), 1'b0);
    drain();
    rand_rdy = 1'b0;
    chk("t2_words", 256'(n_words), 256'd18);

    // Level-held s_tvalid: a new header every 1+NC+1 cycles.
    hdr_cyc.delete();
    for (int p = 0; p < 3; p++) send(rand_set(), 1'b1);
    @(negedge clk);
    s_tvalid = 1'b0;
    drain();
    chk("t3_hdr_count", 256'(hdr_cyc.size()), 256'd3);
    for (int i = 1; i < hdr_cyc.size(); i++)
      chk("t3_hdr_spacing", 256'(hdr_cyc[i] - hdr_cyc[i-1]), 256'(NC + 2));
    chk("t3_frame_cnt", 256'(frame_cnt), 256'(model_cnt));

    // Reset while crop word 2 is on the bus.
    send(rand_set(), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_pre_k", 256'(m_tdata[RW +: 8]), 256'd2);
    reset = 1'b1;
    #1;
    chk("t4_s_tready", 256'(s_tready), 256'd1);
    chk("t4_tvalid", 256'(m_tvalid), 256'd0);
    chk("t4_tlast", 256'(m_tlast), 256'd0);
    chk("t4_tdata", m_tdata, 256'd0);
    chk("t4_busy", 256'(busy), 256'd0);
    chk("t4_frame_cnt", 256'(frame_cnt), 256'd0);
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    send(rand_set(), 1'b0);
    drain();

    // Single-crop instance: two-word packet.
    @(negedge clk);
    s1_tvalid = 1'b1;
    s1_tdata  = RW'(32'hBEEF1234);
    @(posedge clk);
    #1;
    chk("n1_hdr_valid", 256'(m1_tvalid), 256'd1);
    chk("n1_hdr_ncrops", 256'(m1_tdata[71:64]), 256'd1);
    chk("n1_hdr_last", 256'(m1_tlast), 256'd0);
    s1_tvalid = 1'b0;
    @(posedge clk);
    #1;
    chk("n1_crop_res", 256'(m1_tdata[RW-1:0]), 256'(32'hBEEF1234));
    chk("n1_crop_k", 256'(m1_tdata[RW +: 8]), 256'd0);
    chk("n1_crop_last", 256'(m1_tlast), 256'd1);
    @(posedge clk);
    #1;
    chk("n1_end_valid", 256'(m1_tvalid), 256'd0);
    chk("n1_frame_cnt", 256'(frame_cnt1), 256'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rheed_result_packer.md
# rheed_result_packer

Downstream stage of the RHEED inference pipeline. Captures one complete set of per-crop CNN results (NUM_CROPS × 160-bit) and serialises it into a framed 256-bit AXI4-Stream packet for the host DMA path: a header word, then one word per crop. Provides full-packet buffering, so the inference stage can start the next frame while the packet drains under backpressure.

## Interface
- NUM_CROPS, 5: crops per result set; range 1..255.
- RES_W, 160: width of one crop's CNN result; must be ≤ 248.
- MAGIC, 32'h52484545: header identifier.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- s_tvalid  in  1  result set valid.
- s_tready  out  1  packer can accept a set.
- s_tdata  in  NUM_CROPS*RES_W  flattened results; crop k at [k*RES_W +: RES_W].
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  256  output word.
- m_axis_tlast  out  1  last word of packet.
- busy  out  1  packet in flight (state ≠ IDLE).
- frame_cnt  out  32  number of sets accepted since reset.

## Operation
- States: IDLE, HDR, CROP.
- IDLE: s_tready=1. On s_tvalid: latch all NUM_CROPS results into a capture buffer, latch frame_cnt into the header field, then increment frame_cnt (mod 2^32) and go to HDR.
- HDR: drive the header word. On m_axis_tready: crop counter k←0, go to CROP.
- CROP: drive the crop-k word. On m_axis_tready: if k==NUM_CROPS-1, go to IDLE; otherwise k←k+1.
- Header word layout:
  - [31:0]=MAGIC.
  - [63:32]=frame number (value before increment; first packet carries 0).
  - [71:64]=NUM_CROPS.
  - [191:128]=timestamp (see Configuration).
  - All other bits 0.
- Crop word layout: [RES_W-1:0]=result k, [RES_W+7:RES_W]=k, all other bits 0.
- Packet length is exactly 1+NUM_CROPS words. m_axis_tlast=1 only on crop word NUM_CROPS-1. For NUM_CROPS=1, the single crop word carries tlast.
- s_tready=0 in HDR and CROP. The capture buffer is not modified until the packet completes.
- s_tvalid is sampled only in IDLE; a level-held s_tvalid re-accepts on each return to IDLE.

## Timing
- Reset values:
  - s_tready=1.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - busy=0, frame_cnt=0.
  - State IDLE, k=0, timestamp counter 0.
- All outputs are registered except s_tready, which decodes state directly.
- Latency: set accepted at edge N → header valid after edge N; first crop word no earlier than edge N+1.
- Throughput: one word per cycle with tready held high. Back-to-back sets cost (1+NUM_CROPS) cycles plus 1 IDLE cycle each.
- AXI rules:
  - Once m_axis_tvalid=1, it stays high, and tdata/tlast stay stable, until tready=1.
  - m_axis_tvalid never depends combinationally on tready.
- tready low for any number of cycles stalls with no word lost or duplicated.
- Reset mid-packet: the packet is abandoned immediately. No tlast is emitted; the next packet starts at a header.

## Configuration
- RHEED_PACKER_TIMESTAMP_EN defined:
  - A 64-bit free-running cycle counter increments every clk from reset.
  - Its value at the acceptance edge is captured into header [191:128].
- Undefined: the counter is not instantiated and header [191:128]=0.

## Test plan
- Single set, NUM_CROPS=5, crop k result = {152'h0, 8'hA0+k}, tready=1 → 6 consecutive words: header [31:0]=52484545, [63:32]=0, [71:64]=5; crop words [7:0]=A0..A4, [167:160]=0..4; tlast only on word 6; frame_cnt=1.
- Random tready (50%) over 3 sets → 18 words, each stable while stalled; header frame fields 0,1,2; no s_tready during packets.
- s_tvalid held high continuously with tready=1 → new header every 7 cycles; frame_cnt increments by 1 per packet.
- Reset asserted in CROP state at k=2 → all outputs at reset values within the same cycle; next set yields a header with frame field 0.
- With RHEED_PACKER_TIMESTAMP_EN, set accepted 100 cycles after reset release → header [191:128]=100 (±0); without the macro, field=0.
- NUM_CROPS=1 → 2-word packet, tlast on crop word 0, [71:64]=1.
